matmul_output_buffer: RTL and testbench
=======================================

Name: matmul_output_buffer

Overview:
- Downstream stage of systolic_matrix_mult: consumes its C element stream (c_data/c_row/c_col/c_valid, done) and captures it into an M x N Q-format register file.
- Adds a per-column bias with saturation, then re-emits the matrix in strict row-major order over a valid/ready stream.
- Decouples the multiplier's arbitrary output order and timing from the next transformer stage, e.g. activation or the next matmul's A loader.

Parameters:
- DATA_WIDTH, 16, element width, signed two's complement.
- FRAC_WIDTH, 8, fractional bits (Q8.8 default). Informational only; bias add is aligned, so no shift is applied.
- M, 4, rows of C.
- N, 2, cols of C.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new capture and clears the written mask
- c_data  in  DATA_WIDTH  signed result element from multiplier
- c_row  in  $clog2(M)  element row index
- c_col  in  $clog2(N)  element column index
- c_valid  in  1  c_* qualifier
- c_done  in  1  multiplier done; ends capture
- bias_data  in  DATA_WIDTH  signed bias value
- bias_col  in  $clog2(N)  bias column index
- bias_valid  in  1  bias write strobe
- out_data  out  DATA_WIDTH  biased element
- out_row  out  $clog2(M)  row of out_data
- out_col  out  $clog2(N)  column of out_data
- out_valid  out  1  output qualifier
- out_ready  in  1  downstream accept
- out_last  out  1  high with element (M-1, N-1)
- busy  out  1  high in COLLECT or DRAIN
- err  out  1  sticky protocol error flag

Behaviour:
- Reset: every output is 0. Result registers, bias registers and written mask are cleared. State is IDLE.
- States:
  - IDLE -> COLLECT on start.
  - COLLECT -> DRAIN on c_done.
  - DRAIN -> IDLE on the cycle the last element is accepted (out_valid & out_ready & out_last).
  - start in any state forces COLLECT next cycle, clears the written mask, drops out_valid and aborts any drain. Result and bias registers are not cleared by start.
- COLLECT:
  - On c_valid, store c_data at [c_row][c_col] and set its mask bit.
  - A write to a cell whose mask bit is already set still overwrites the cell and sets err.
  - Indices >= M or >= N are dropped and set err.
  - c_valid together with c_done in the same cycle: the element is stored, then the block transitions to DRAIN.
  - c_done with any mask bit clear sets err. Unwritten cells drain their stale or reset value.
- Bias:
  - bias_valid is accepted in IDLE and COLLECT and writes bias[bias_col].
  - Bias persists across starts. bias_valid in DRAIN is ignored and sets err.
- DRAIN:
  - The cycle after c_done is sampled, out_valid=1 with element (0,0).
  - out_data = sat(C[r][c] + bias[c]), a (DATA_WIDTH+1)-bit sum saturated to 0x7FFF / 0x8000. The result is registered.
  - The element advances only when out_valid & out_ready. out_data/out_row/out_col/out_last are held stable while out_valid & !out_ready.
  - Throughput is 1 element/cycle. Order is r=0..M-1, and c=0..N-1 within each row.
  - After the last element is accepted, out_valid=0 next cycle.
- c_valid or c_done during DRAIN or IDLE: ignored, err set.
- err: cleared only by reset or by start.
- busy: 1 from the cycle after start through the cycle the last element is accepted.
- Reset mid-operation: immediately returns all state and outputs to reset values.

Optional Feature:
- Macro: MATMUL_OUT_RELU_EN.
- When defined: out_data = max(0, sat(C+bias)), applied after saturation. Negative results become 0x0000.
- When undefined: no clamp. The signed saturated sum is emitted unchanged.
- Timing is identical in both builds.

Test Plan:
- Basic drain:
  - Stimulus: C = [[1,2],[3,4],[5,6],[3,1]] Q8.8 (0x0100...) delivered in reverse order; bias = [0x0080, 0xFF00]; c_done; out_ready=1.
  - Response: row-major out 0x0180, 0x0100, 0x0380, 0x0300, 0x0580, 0x0500, 0x0380, 0x0000; out_last on the 8th element; err=0.
- Saturation:
  - C[0][0]=0x7F00 with bias 0x0200 -> 0x7FFF.
  - C[0][1]=0x8100 with bias 0xFE00 -> 0x8000.
- Backpressure: hold out_ready=0 for 3 cycles at element (1,1) -> out_data=0x0300, row=1, col=1 held stable; sequence resumes without loss or duplication.
- Errors:
  - Duplicate write to (2,0) -> err=1 and the second value is drained.
  - c_done with (3,1) missing -> err=1.
  - The next start clears err.
- RELU build: C=0x0100 with bias 0xFE00 -> 0x0000 when MATMUL_OUT_RELU_EN is defined, 0xFF00 when it is not.
- Abort: assert rst_n=0, or start, mid-drain after 3 elements -> out_valid=0 next cycle (immediately for reset); busy=0 (IDLE) after reset, busy=1 (COLLECT) after start.

Source files
------------

// File: rtl/matmul_output_buffer.sv
// Captures the systolic C stream, adds per-column bias with saturation, and
// re-emits it row-major over valid/ready. Optional clamp: MATMUL_OUT_RELU_EN.
module matmul_output_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int M          = 4,
    parameter int N          = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] c_data,
    input  logic [$clog2(M)-1:0]  c_row,
    input  logic [$clog2(N)-1:0]  c_col,
    input  logic                  c_valid,
    input  logic                  c_done,
    input  logic [DATA_WIDTH-1:0] bias_data,
    input  logic [$clog2(N)-1:0]  bias_col,
    input  logic                  bias_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [$clog2(M)-1:0]  out_row,
    output logic [$clog2(N)-1:0]  out_col,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err
);
    localparam int DW = DATA_WIDTH;
    localparam int RW = $clog2(M);
    localparam int CW = $clog2(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(M - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

    if (FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
        $error("FRAC_WIDTH must be below DATA_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
    state_t state_q, state_d;

    logic [DW-1:0]       mem_q  [M][N];
    logic [DW-1:0]       bias_q [N];
    logic [M-1:0][N-1:0] mask_q, mask_d;

    logic          c_in_range, b_in_range;
    logic          wr_en, bias_wr, accept;
    logic          first_ld, next_ld, err_set;
    logic [RW-1:0] ld_row;
    logic [CW-1:0] ld_col;
    logic [DW-1:0] ld_c, ld_b, sat, res;
    logic [DW:0]   sum;

    assign busy = (state_q != IDLE);

    always_comb begin
        c_in_range = (int'(c_row) < M) && (int'(c_col) < N);
        b_in_range = int'(bias_col) < N;
        wr_en      = !start && state_q == COLLECT && c_valid
                     && c_in_range;
        bias_wr    = bias_valid && state_q != DRAIN && b_in_range;
        accept     = out_valid && out_ready;
        first_ld   = !start && state_q == COLLECT && c_done;
        next_ld    = !start && state_q == DRAIN && accept
                     && !out_last;
    end

    always_comb begin
        mask_d = mask_q;
        if (wr_en) begin
            mask_d[c_row][c_col] = 1'b1;
        end
    end

    always_comb begin
        err_set = 1'b0;
        case (state_q)
            COLLECT: begin
                if (c_valid && !c_in_range) begin
                    err_set = 1'b1;
                end
                if (c_valid && c_in_range && mask_q[c_row][c_col]) begin
                    err_set = 1'b1;
                end
                if (c_done && !(&mask_d)) begin
                    err_set = 1'b1;
                end
            end
            default: begin
                if (c_valid || c_done) begin
                    err_set = 1'b1;
                end
                if (state_q == DRAIN && bias_valid) begin
                    err_set = 1'b1;
                end
            end
        endcase
    end

    // Element to load next; the first load bypasses same-cycle writes
    always_comb begin
        if (state_q == COLLECT) begin
            ld_row = '0;
            ld_col = '0;
        end else if (out_col == LAST_COL) begin
            ld_row = out_row + 1'b1;
            ld_col = '0;
        end else begin
            ld_row = out_row;
            ld_col = out_col + 1'b1;
        end
        ld_c = mem_q[ld_row][ld_col];
        if (wr_en && c_row == ld_row && c_col == ld_col) begin
            ld_c = c_data;
        end
        ld_b = bias_q[ld_col];
        if (bias_wr && bias_col == ld_col) begin
            ld_b = bias_data;
        end
    end

    always_comb begin
        sum = {ld_c[DW-1], ld_c} + {ld_b[DW-1], ld_b};
        if (sum[DW] != sum[DW-1]) begin
            sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}}
                          : {1'b0, {(DW-1){1'b1}}};
        end else begin
            sat = sum[DW-1:0];
        end
`ifdef MATMUL_OUT_RELU_EN
        res = sat[DW-1] ? '0 : sat;
`else
        res = sat;
`endif
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                COLLECT: if (c_done) state_d = DRAIN;
                DRAIN:   if (accept && out_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < M; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
            for (int c = 0; c < N; c++) begin
                bias_q[c] <= '0;
            end
            mask_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[c_row][c_col] <= c_data;
            end
            if (bias_wr) begin
                bias_q[bias_col] <= bias_data;
            end
            mask_q <= start ? '0 : mask_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (start) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (first_ld || next_ld) begin
            out_data  <= res;
            out_row   <= ld_row;
            out_col   <= ld_col;
            out_valid <= 1'b1;
            out_last  <= (ld_row == LAST_ROW) && (ld_col == LAST_COL);
        end else if (state_q == DRAIN && accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (start) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matmul_output_buffer.sv
// Bench for matmul_output_buffer: table vectors, hand sequences and
// randomized captures checked against an arithmetic reference model.
module tb_matmul_output_buffer;
    localparam int M  = 4;
    localparam int N  = 2;
    localparam int DW = 16;
    localparam int RW = $clog2(M);
    localparam int CW = $clog2(N);

    logic          clk, rst_n, start;
    logic [DW-1:0] c_data, bias_data, out_data;
    logic [RW-1:0] c_row, out_row;
    logic [CW-1:0] c_col, bias_col, out_col;
    logic          c_valid, c_done, bias_valid;
    logic          out_valid, out_ready, out_last, busy, err;

    matmul_output_buffer #(
        .DATA_WIDTH(DW), .FRAC_WIDTH(8), .M(M), .N(N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .c_data(c_data), .c_row(c_row), .c_col(c_col),
        .c_valid(c_valid), .c_done(c_done),
        .bias_data(bias_data), .bias_col(bias_col),
        .bias_valid(bias_valid),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    logic [DW-1:0] cm [M][N];
    logic [DW-1:0] bm [N];
    bit            mk [M][N];
    bit            exp_err;

    typedef struct {
        string         name;
        logic [DW-1:0] c;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] c,
                                              input logic [DW-1:0] b);
        int s;
        s = int'($signed(c)) + int'($signed(b));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef MATMUL_OUT_RELU_EN
        if (s < 0) s = 0;
`endif
        return DW'(s);
    endfunction

    function automatic logic [DW-1:0] rnd16();
        logic [DW-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 16'h7FFF;
            1: v = 16'h8000;
            2: v = 16'h7F00 + DW'($urandom_range(0, 255));
            default: v = DW'($urandom_range(0, 65535));
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                cm[r][c] = '0;
                mk[r][c] = 1'b0;
            end
        end
        for (int c = 0; c < N; c++) bm[c] = '0;
        exp_err = 1'b0;
    endtask

    task automatic check_missing();
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!mk[r][c]) exp_err = 1'b1;
            end
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) mk[r][c] = 1'b0;
        end
        exp_err = 1'b0;
    endtask

    task automatic write_bias(input int col, input logic [DW-1:0] d);
        bias_valid = 1'b1;
        bias_col   = CW'(col);
        bias_data  = d;
        tick();
        bias_valid = 1'b0;
        bm[col] = d;
    endtask

    task automatic write_c(input int r, input int c,
                           input logic [DW-1:0] d, input bit done);
        c_valid = 1'b1;
        c_done  = done;
        c_row   = RW'(r);
        c_col   = CW'(c);
        c_data  = d;
        tick();
        c_valid = 1'b0;
        c_done  = 1'b0;
        if (mk[r][c]) exp_err = 1'b1;
        cm[r][c] = d;
        mk[r][c] = 1'b1;
        if (done) check_missing();
    endtask

    task automatic send_done();
        c_done = 1'b1;
        tick();
        c_done = 1'b0;
        check_missing();
    endtask

    // mode 0: ready high except 3 stall cycles at stall_idx; mode 1: random
    task automatic drain(input int mode, input int stall_idx,
                         input int stop_after);
        int idx, cyc, stalls, r, c;
        idx = 0;
        cyc = 0;
        stalls = 0;
        while (idx < stop_after && cyc < 400) begin
            r = idx / N;
            c = idx % N;
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, ref_out(cm[r][c], bm[c]));
            chk("drain_row", out_row, r);
            chk("drain_col", out_col, c);
            chk("drain_last", out_last, (idx == M * N - 1) ? 1 : 0);
            chk("drain_busy", busy, 1);
            if (mode == 1) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else if (idx == stall_idx && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            tick();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        if (cyc >= 400) chk("drain_timeout", 0, 1);
    endtask

    task automatic write_all(input bit reverse);
        for (int i = 0; i < M * N; i++) begin
            int k;
            k = reverse ? (M * N - 1 - i) : i;
            write_c(k / N, k % N, cm[k / N][k % N], 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int perm [M * N];
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        c_data = '0;
        c_row = '0;
        c_col = '0;
        c_valid = 1'b0;
        c_done = 1'b0;
        bias_data = '0;
        bias_col = '0;
        bias_valid = 1'b0;
        out_ready = 1'b0;
        model_clear();

        tbl[0] = '{"sat_pos",   16'h7F00, 16'h0200, 16'h7FFF};
        tbl[1] = '{"sat_neg",   16'h8100, 16'hFE00, 16'h8000};
        tbl[2] = '{"neg_small", 16'h0100, 16'hFE00, 16'hFF00};
        tbl[3] = '{"plain",     16'h0100, 16'h0080, 16'h0180};
        tbl[4] = '{"to_zero",   16'hFFFF, 16'h0001, 16'h0000};
        tbl[5] = '{"min_min",   16'h8000, 16'h8000, 16'h8000};
        tbl[6] = '{"max_max",   16'h7FFF, 16'h7FFF, 16'h7FFF};
        tbl[7] = '{"max_one",   16'h7FFF, 16'h0001, 16'h7FFF};
        tbl[8] = '{"min_max",   16'h8000, 16'h7FFF, 16'hFFFF};
        tbl[9] = '{"no_sat",    16'h7F00, 16'h00FF, 16'h7FFF};
`ifdef MATMUL_OUT_RELU_EN
        tbl[1].exp = 16'h0000;
        tbl[2].exp = 16'h0000;
        tbl[5].exp = 16'h0000;
        tbl[8].exp = 16'h0000;
`endif

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_row", out_row, 0);
        chk("reset_col", out_col, 0);
        chk("reset_last", out_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);

        c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        chk("idle_cvalid_err", err, 1);

        // basic drain, bias loaded in IDLE, C delivered in reverse order
        write_bias(0, 16'h0080);
        write_bias(1, 16'hFF00);
        start_pulse();
        chk("start_clears_err", err, 0);
        chk("busy_collect", busy, 1);
        cm[0][0] = 16'h0100; cm[0][1] = 16'h0200;
        cm[1][0] = 16'h0300; cm[1][1] = 16'h0400;
        cm[2][0] = 16'h0500; cm[2][1] = 16'h0600;
        cm[3][0] = 16'h0300; cm[3][1] = 16'h0100;
        write_all(1'b1);
        send_done();
        drain(0, -1, M * N);
        chk("basic_end_valid", out_valid, 0);
        chk("basic_end_busy", busy, 0);
        chk("basic_err", err, exp_err);

        // backpressure at element (1,1)
        start_pulse();
        write_all(1'b0);
        send_done();
        drain(0, 3, M * N);
        chk("bp_err", err, exp_err);

        for (int i = 0; i < 10; i++) begin
            start_pulse();
            write_bias(0, tbl[i].b);
            write_bias(1, 16'h0000);
            write_c(0, 0, tbl[i].c, 1'b0);
            send_done();
            chk(tbl[i].name, out_data, tbl[i].exp);
        end

        // duplicate write to (2,0)
        start_pulse();
        write_all(1'b0);
        write_c(2, 0, 16'h0AAA, 1'b0);
        chk("dup_err", err, 1);
        send_done();
        drain(0, -1, M * N);
        chk("dup_err_hold", err, exp_err);

        // missing (3,1), plus bias write while draining
        start_pulse();
        chk("err_cleared", err, 0);
        for (int k = 0; k < M * N - 1; k++) begin
            write_c(k / N, k % N, DW'(16'h0010 * k), 1'b0);
        end
        send_done();
        chk("missing_err", err, 1);
        bias_valid = 1'b1;
        bias_col = '0;
        bias_data = 16'h1234;
        tick();
        bias_valid = 1'b0;
        drain(0, -1, M * N);
        chk("missing_err_hold", err, exp_err);

        for (int it = 0; it < 15; it++) begin
            start_pulse();
            for (int b = 0; b < int'($urandom_range(0, 2)); b++) begin
                write_bias(int'($urandom_range(0, N - 1)), rnd16());
            end
            for (int k = 0; k < M * N; k++) perm[k] = k;
            for (int k = M * N - 1; k > 0; k--) begin
                int j, t;
                j = int'($urandom_range(0, k));
                t = perm[k];
                perm[k] = perm[j];
                perm[j] = t;
            end
            for (int k = 0; k < M * N; k++) begin
                bit dn;
                dn = (k == M * N - 1) && ($urandom_range(0, 1) == 1);
                write_c(perm[k] / N, perm[k] % N, rnd16(), dn);
                if (k == M * N - 1 && !dn) send_done();
                if ($urandom_range(0, 3) == 0 && k != M * N - 1) tick();
            end
            drain(1, -1, M * N);
            chk("rand_err", err, exp_err);
            chk("rand_idle", busy, 0);
        end

        // reset mid-drain after 3 elements
        start_pulse();
        write_all(1'b0);
        send_done();
        drain(0, -1, 3);
        rst_n = 1'b0;
        #1;
        chk("rst_abort_valid", out_valid, 0);
        chk("rst_abort_busy", busy, 0);
        chk("rst_abort_data", out_data, 0);
        #3;
        rst_n = 1'b1;
        model_clear();
        tick();

        // start mid-drain after 3 elements
        write_bias(1, 16'h0040);
        start_pulse();
        for (int k = 0; k < M * N; k++) cm[k / N][k % N] = rnd16();
        write_all(1'b0);
        send_done();
        drain(0, -1, 3);
        start_pulse();
        chk("start_abort_valid", out_valid, 0);
        chk("start_abort_busy", busy, 1);
        write_all(1'b1);
        send_done();
        drain(1, -1, M * N);
        chk("final_err", err, exp_err);
        chk("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
